// File: rtl/freq_divider_22khz.sv
// Fractional (accumulator) clock divider: toggles clk_22KHz 2*OUT_HZ times per CLK_HZ input
// cycles, so the long-term output frequency is exactly OUT_HZ with at most one cycle of jitter.
module freq_divider_22khz #(
  parameter int CLK_HZ = 27_000_000,
  parameter int OUT_HZ = 22_050
) (
  input  logic clk_27MHz,
  input  logic reset,
  output logic clk_22KHz
);

  // Wide enough for the largest pre-subtraction sum: (CLK_HZ - 1) + 2*OUT_HZ.
  localparam int ACC_W = $clog2(CLK_HZ + 2 * OUT_HZ);
  localparam logic [ACC_W-1:0] STEP  = ACC_W'(2 * OUT_HZ);
  localparam logic [ACC_W-1:0] LIMIT = ACC_W'(CLK_HZ);

  if (OUT_HZ <= 0 || 2 * OUT_HZ > CLK_HZ) begin : g_bad_params
    $error("freq_divider_22khz: need 0 < 2*OUT_HZ <= CLK_HZ (CLK_HZ=%0d OUT_HZ=%0d)",
           CLK_HZ, OUT_HZ);
  end

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;

  // acc stays below CLK_HZ, so this add never wraps at ACC_W bits.
  assign sum = acc + STEP;

  always_ff @(posedge clk_27MHz or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      clk_22KHz <= 1'b0;
    end else if (sum >= LIMIT) begin
      acc       <= sum - LIMIT;
      clk_22KHz <= ~clk_22KHz;
    end else begin
      acc       <= sum;
    end
  end

endmodule

// File: tb/tb_freq_divider_22khz.sv
// Directed bench for freq_divider_22khz: default 27 MHz / 22.05 kHz instance plus an
// exact-ratio (100/10) and a fractional (1000/30) instance sharing clock and reset.
`timescale 1ns/100ps
module tb_freq_divider_22khz;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic out_main, out_exact, out_frac;
  int   n_cmp = 0;
  int   n_err = 0;

  always #18 clk = ~clk;

  freq_divider_22khz dut (
    .clk_27MHz (clk),
    .reset     (rst),
    .clk_22KHz (out_main)
  );

  freq_divider_22khz #(.CLK_HZ(100), .OUT_HZ(10)) dut_exact (
    .clk_27MHz (clk),
    .reset     (rst),
    .clk_22KHz (out_exact)
  );

  freq_divider_22khz #(.CLK_HZ(1000), .OUT_HZ(30)) dut_frac (
    .clk_27MHz (clk),
    .reset     (rst),
    .clk_22KHz (out_frac)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Per-instance tracking: index 0 = main, 1 = exact, 2 = frac.
  logic o[3];
  logic prev[3];
  int   toggles[3];
  int   first_t[3];
  int   last_t[3];
  int   bad_hp[3];
  int   hp_lo[3]   = '{612, 5, 16};
  int   hp_hi[3]   = '{613, 5, 17};
  int   exp_first[3] = '{613, 5, 17};
  int   exp_tog[3]   = '{44, 5400, 1620};
  string name[3]   = '{"main", "exact", "frac"};

  initial begin
    int rise_edge;
    bit seen;

    // Reset held for three clocks (> 100 ns): everything stays low.
    repeat (3) begin
      @(negedge clk);
      check("reset_out", {29'd0, out_frac, out_exact, out_main}, 32'd0);
    end
    check("reset_acc_main", int'(dut.acc), 0);
    rst = 1'b0;

    for (int k = 0; k < 3; k++) begin
      prev[k] = 1'b0; toggles[k] = 0; first_t[k] = 0; last_t[k] = 0; bad_hp[k] = 0;
    end

    // Free-run 27000 edges (1 ms at 27 MHz), tracking every toggle.
    for (int n = 1; n <= 27000; n++) begin
      @(posedge clk); #1;
      o[0] = out_main; o[1] = out_exact; o[2] = out_frac;
      for (int k = 0; k < 3; k++) begin
        if (o[k] !== prev[k]) begin
          toggles[k]++;
          if (toggles[k] == 1) first_t[k] = n;
          else if ((n - last_t[k]) < hp_lo[k] || (n - last_t[k]) > hp_hi[k]) bad_hp[k]++;
          last_t[k] = n;
        end
        prev[k] = o[k];
      end
      if (n == 100) begin
        check("exact_acc_at_100", int'(dut_exact.acc), 0);
        check("exact_toggles_at_100", toggles[1], 20);
      end
      if (n == 1000) begin
        check("frac_acc_at_1000", int'(dut_frac.acc), 0);
        check("frac_toggles_at_1000", toggles[2], 60);
      end
    end

    for (int k = 0; k < 3; k++) begin
      check({name[k], "_first_rise_edge"}, first_t[k], exp_first[k]);
      check({name[k], "_toggles_27000"}, toggles[k], exp_tog[k]);
      check({name[k], "_bad_half_periods"}, bad_hp[k], 0);
    end
    // Toggle 1 at edge 613, toggle 44 at ceil(44*27e6/44100) = 26939.
    check("main_span_43_half_periods", last_t[0] - first_t[0], 26326);
    check("main_acc_at_27000", int'(dut.acc), 2_700_000);

    // Move into a high phase of the main output.
    seen = 0;
    for (int n = 0; n < 1300 && !seen; n++) begin
      @(posedge clk); #1;
      if (out_main === 1'b1) seen = 1;
    end
    check("main_reaches_high", seen, 1);
    repeat (10) @(posedge clk);
    #5;
    check("main_high_before_reset", out_main, 1);

    // Asynchronous reset between edges: output and accumulator clear with no clock edge.
    rst = 1'b1;
    #1;
    check("async_reset_out", out_main, 0);
    check("async_reset_acc", int'(dut.acc), 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("held_reset_out", out_main, 0);
    end
    @(negedge clk);
    rst = 1'b0;

    rise_edge = 0;
    for (int n = 1; n <= 1300 && rise_edge == 0; n++) begin
      @(posedge clk); #1;
      if (out_main === 1'b1) rise_edge = n;
    end
    check("rise_after_rerelease", rise_edge, 613);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
